ram_dp_be: RTL and testbench

//  Parameterised dual-port inferred RAM (one write port, one read port, one clock): next generation of our basic dual-port RAM.

---
 rtl/ram_pkg.sv | 10 +
 rtl/ram_clear_seq.sv | 42 ++++
 rtl/ram_dp_be.sv | 69 ++++++
 tb/tb_ram_dp_be.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared lane helpers and clear-sequencer state type for the byte-enable RAM family
package ram_pkg;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
  function automatic int lanes(input int dw, input int bw);
    return dw / bw;
  endfunction
  function automatic bit width_ok(input int dw, input int bw);
    return (dw % bw) == 0;
  endfunction
endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: post-reset zero sweep; owns the RAM write port while busy
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH      = 9,
  parameter int DATAWIDTH      = 36,
  parameter int LANES          = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic [LANES-1:0]     wr_be,
  output logic                 busy,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_data,
  output logic [LANES-1:0]     mem_be
);
  clr_state_t state, state_nx;
  logic [ADDRWIDTH-1:0] clr_addr, clr_addr_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end
  always_comb begin
    state_nx    = (state == CLR_RUN && clr_addr == '1) ? CLR_IDLE : state;
    clr_addr_nx = (state == CLR_RUN) ? clr_addr + 1'b1 : clr_addr;
    busy        = state == CLR_RUN;
    mem_we      = busy | we;
    mem_addr    = busy ? clr_addr : wr_addr;
    mem_data    = busy ? '0 : wr_data;
    mem_be      = busy ? '1 : wr_be;
  end
endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port byte-enable RAM with read bypass, optional output register and clear sweep
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int DATAWIDTH      = 36,
  parameter int ADDRWIDTH      = 9,
  parameter int BYTEWIDTH      = 9,
  parameter int OUTREG         = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = lanes(DATAWIDTH, BYTEWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic [ADDRWIDTH-1:0] wr_addr,
  input  logic                 we,
  input  logic [LANES-1:0]     wr_be,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  input  logic                 re,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy
);
  if (!width_ok(DATAWIDTH, BYTEWIDTH)) begin : g_bad_width
    $error("DATAWIDTH must be a multiple of BYTEWIDTH");
  end
  logic                 mem_we, rd_en, v1;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_data, q;
  logic [LANES-1:0]     mem_be;
  ram_clear_seq #(
    .ADDRWIDTH(ADDRWIDTH), .DATAWIDTH(DATAWIDTH), .LANES(LANES), .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be)
  );
  assign rd_en = re && !busy;
  // one array per lane keeps each lane's write enable independent
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BYTEWIDTH-1:0] mem [1<<ADDRWIDTH];
    logic [BYTEWIDTH-1:0] q_l;
    always_ff @(posedge clk) begin
      if (mem_we && mem_be[l]) mem[mem_addr] <= mem_data[l*BYTEWIDTH +: BYTEWIDTH];
    end
    always_ff @(posedge clk) begin
      if (reset) q_l <= '0;
      else if (rd_en)
        q_l <= (BYPASS != 0 && mem_we && mem_be[l] && mem_addr == rd_addr)
             ? mem_data[l*BYTEWIDTH +: BYTEWIDTH] : mem[rd_addr];
    end
    assign q[l*BYTEWIDTH +: BYTEWIDTH] = q_l;
  end
  always_ff @(posedge clk) v1 <= reset ? 1'b0 : rd_en;
  if (OUTREG != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= v1;
        if (v1) rd_data <= q;
      end
    end
  end else begin : g_noreg
    assign rd_data  = q;
    assign rd_valid = v1;
  end
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: directed checks of clear sweep, lane writes, bypass, streaming reads and reset drop
module tb_ram_dp_be;
  logic        clk = 0, reset = 1, we = 0, re = 0;
  logic [35:0] wr_data = '0, rd_data;
  logic [3:0]  wr_addr = '0, rd_addr = '0, wr_be = '0;
  logic        rd_valid, busy;
  int          n_chk = 0, n_fail = 0;
  ram_dp_be #(.ADDRWIDTH(4)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .we(we), .wr_be(wr_be),
    .rd_addr(rd_addr), .re(re), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [35:0] d, input logic [3:0] be);
    we = 1; wr_addr = a; wr_data = d; wr_be = be;
    tick;
    we = 0; wr_be = '0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [35:0] exp);
    re = 1; rd_addr = a;
    tick;
    re = 0;
    chk({tag, "_early"}, 36'(rd_valid), 36'd0);
    tick;
    chk({tag, "_vld"}, 36'(rd_valid), 36'd1);
    chk({tag, "_data"}, rd_data, exp);
  endtask
  task automatic sweep_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick;
    end
  endtask
  task automatic stream(input string tag, input int n, input bit zero);
    for (int c = 0; c <= n + 1; c++) begin
      re = (c < n); rd_addr = 4'(c);
      tick;
      if (c >= 1 && c <= n) begin
        chk($sformatf("%s_vld%0d", tag, c), 36'(rd_valid), 36'd1);
        chk($sformatf("%s_data%0d", tag, c), rd_data, zero ? 36'd0 : 36'h100 + 36'((c - 1) % 16));
      end else chk($sformatf("%s_idle%0d", tag, c), 36'(rd_valid), 36'd0);
    end
    re = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n, vseen;
    reset = 1;
    tick;
    chk("rst_busy", 36'(busy), 36'd1);
    chk("rst_vld", 36'(rd_valid), 36'd0);
    chk("rst_data", rd_data, 36'd0);
    reset = 0;
    sweep_len(n);
    chk("busy_len", 36'(n), 36'd16);
    chk("busy_done", 36'(busy), 36'd0);
    stream("clr", 16, 1);
    wr(4'd5, 36'h123456789, 4'b1111);
    rd("t2", 4'd5, 36'h123456789);
    wr(4'd7, 36'hFFFFFFFFF, 4'b1111);
    wr(4'd7, 36'h0, 4'b0101);
    rd("t3", 4'd7, 36'hFF803FE00);
    wr(4'd7, 36'h155, 4'b0000);
    rd("be0", 4'd7, 36'hFF803FE00);
    wr(4'd3, 36'hABCDEF012, 4'b1111);
    we = 1; wr_addr = 4'd3; wr_data = 36'h987654321; wr_be = 4'b0011; re = 1; rd_addr = 4'd3;
    tick;
    we = 0; re = 0; wr_be = '0;
    tick;
    chk("t4_vld", 36'(rd_valid), 36'd1);
    chk("t4_bypass", rd_data, 36'hABCDD4321);
    rd("t4_after", 4'd3, 36'hABCDD4321);
    for (int i = 0; i < 16; i++) wr(4'(i), 36'h100 + 36'(i), 4'b1111);
    stream("seq", 20, 0);
    for (int c = 0; c < 15; c++) begin
      re = 1; rd_addr = 4'(c); reset = (c == 10);
      tick;
      if (c >= 1 && c <= 9) begin
        chk($sformatf("drop_vld%0d", c), 36'(rd_valid), 36'd1);
        chk($sformatf("drop_data%0d", c), rd_data, 36'h100 + 36'(c - 1));
      end else if (c >= 10) chk($sformatf("drop_none%0d", c), 36'(rd_valid), 36'd0);
      if (c == 10) chk("drop_rst_data", rd_data, 36'd0);
    end
    reset = 0; re = 0;
    reset = 1;
    tick;
    reset = 0;
    repeat (9) tick;
    reset = 1;
    tick;
    reset = 0;
    n = 0; vseen = 0;
    while (busy && n < 40) begin
      we = (n == 3); wr_addr = 4'd2; wr_data = 36'hFFFFFFFFF; wr_be = 4'b1111;
      re = 1; rd_addr = 4'd2;
      n++;
      tick;
      if (rd_valid) vseen++;
    end
    we = 0; re = 0; wr_be = '0;
    chk("restart_len", 36'(n), 36'd16);
    chk("busy_no_vld", 36'(vseen), 36'd0);
    rd("mask_we", 4'd2, 36'd0);
    rd("clr9", 4'd9, 36'd0);
    rd("clr15", 4'd15, 36'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
